// File: rtl/axi4lite_arb2.sv
// Two-to-one AXI4-Lite arbiter: round-robin between two masters, one transaction
// outstanding at a time, address/data/response forwarded to the granted master.
module axi4lite_arb2 #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              aclk,
    input  logic              areset_n,
    // master 0
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [ADDR_W-1:2] m0_awaddr,
    input  logic [2:0]        m0_awprot,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    output logic [1:0]        m0_bresp,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:2] m0_araddr,
    input  logic [2:0]        m0_arprot,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [31:0]       m0_rdata,
    output logic [1:0]        m0_rresp,
    // master 1
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [ADDR_W-1:2] m1_awaddr,
    input  logic [2:0]        m1_awprot,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [1:0]        m1_bresp,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:2] m1_araddr,
    input  logic [2:0]        m1_arprot,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [31:0]       m1_rdata,
    output logic [1:0]        m1_rresp,
    // slave
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [ADDR_W-1:2] s_awaddr,
    output logic [2:0]        s_awprot,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    input  logic              s_bvalid,
    output logic              s_bready,
    input  logic [1:0]        s_bresp,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:2] s_araddr,
    output logic [2:0]        s_arprot,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [31:0]       s_rdata,
    input  logic [1:0]        s_rresp,
    // status
    output logic              busy,
    output logic              grant
);

    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_WB, ST_RD, ST_RR} state_t;

    state_t state, state_next;
    logic   rr, rr_next;
    logic   grant_next;
    logic   aw_done, aw_done_next;
    logic   w_done, w_done_next;
    logic   sel, aw_hs, w_hs;

    logic wr_req0, wr_req1, req0, req1;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    assign wr_req0 = m0_awvalid & m0_wvalid;
    assign wr_req1 = m1_awvalid & m1_wvalid;
    assign req0    = wr_req0 | m0_arvalid;
    assign req1    = wr_req1 | m1_arvalid;

    // Granted-master view of the handshake inputs and the forwarded payload
    assign g_awvalid = grant ? m1_awvalid : m0_awvalid;
    assign g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
    assign g_bready  = grant ? m1_bready  : m0_bready;
    assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
    assign g_rready  = grant ? m1_rready  : m0_rready;

    assign s_awaddr = grant ? m1_awaddr : m0_awaddr;
    assign s_awprot = grant ? m1_awprot : m0_awprot;
    assign s_wdata  = grant ? m1_wdata  : m0_wdata;
    assign s_wstrb  = grant ? m1_wstrb  : m0_wstrb;
    assign s_araddr = grant ? m1_araddr : m0_araddr;
    assign s_arprot = grant ? m1_arprot : m0_arprot;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= ST_IDLE;
            rr      <= 1'b0;
            grant   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            rr      <= rr_next;
            grant   <= grant_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    always_comb begin
        state_next   = state;
        rr_next      = rr;
        grant_next   = grant;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        sel          = rr;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;

        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;

        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m0_bresp   = 2'b00;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = 32'h0;
        m0_rresp   = 2'b00;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = 2'b00;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = 32'h0;
        m1_rresp   = 2'b00;

        unique case (state)
            ST_IDLE: begin
                // rr holds the priority master; a lone requester wins outright
                if (req0 | req1) begin
                    sel        = (req0 & req1) ? rr : req1;
                    grant_next = sel;
                    state_next = (sel ? wr_req1 : wr_req0) ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                s_awvalid = g_awvalid & ~aw_done;
                s_wvalid  = g_wvalid & ~w_done;
                aw_hs     = s_awvalid & s_awready;
                w_hs      = s_wvalid & s_wready;
                if (grant) begin
                    m1_awready = s_awready & ~aw_done;
                    m1_wready  = s_wready & ~w_done;
                end else begin
                    m0_awready = s_awready & ~aw_done;
                    m0_wready  = s_wready & ~w_done;
                end
                aw_done_next = aw_done | aw_hs;
                w_done_next  = w_done | w_hs;
                if (aw_done_next & w_done_next) state_next = ST_WB;
            end
            ST_WB: begin
                s_bready = g_bready;
                if (grant) begin
                    m1_bvalid = s_bvalid;
                    m1_bresp  = s_bresp;
                end else begin
                    m0_bvalid = s_bvalid;
                    m0_bresp  = s_bresp;
                end
                if (s_bvalid & g_bready) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    rr_next      = ~grant;
                    state_next   = ST_IDLE;
                end
            end
            ST_RD: begin
                s_arvalid = g_arvalid;
                if (grant) m1_arready = s_arready;
                else       m0_arready = s_arready;
                if (g_arvalid & s_arready) state_next = ST_RR;
            end
            ST_RR: begin
                s_rready = g_rready;
                if (grant) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
                if (s_rvalid & g_rready) begin
                    rr_next    = ~grant;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
